// File: rtl/equ_demapper.sv
// Soft demapper: captures one OFDM symbol of 12 equalized subcarriers and
// streams signed LLR pairs (QPSK) or single LLRs (BPSK) under a valid/ready
// handshake, with symbol/slot completion pulses and a sticky overflow flag.
//
// state | meaning
// ------+----------------------------------------------------------
// IDLE  | waiting for an equalized symbol
// SEND  | serializing captured subcarriers, one per accepted transfer
// DONE  | one-cycle symbol completion; may capture the next symbol
module equ_demapper #(
    parameter int DATA_WIDTH = 16,
    parameter int FRAC_WIDTH = 12,
    parameter int LLR_WIDTH  = 8
) (
    input  logic                        i_clk_demap,
    input  logic                        i_rst_n,
    input  logic [2*DATA_WIDTH-1:0]     i_equ [11:0],
    input  logic                        i_done_equ,
    input  logic                        i_mod_qpsk,
    input  logic                        i_ready,
    output logic [LLR_WIDTH-1:0]        o_llr0,
    output logic [LLR_WIDTH-1:0]        o_llr1,
    output logic                        o_valid,
    output logic [3:0]                  o_sc_idx,
    output logic                        o_busy,
    output logic                        o_done_demap_symbol,
    output logic                        o_done_demap_slot,
    output logic                        o_overflow
);

    // LLRs keep 5 fractional bits for QPSK; BPSK drops one more to absorb the re+im sum.
    localparam int QPSK_SHIFT = FRAC_WIDTH - 5;
    localparam int BPSK_SHIFT = FRAC_WIDTH - 4;
    localparam int SW         = DATA_WIDTH + 1;
    localparam logic signed [SW-1:0] LLR_MAX = SW'((1 << (LLR_WIDTH - 1)) - 1);
    localparam logic signed [SW-1:0] LLR_MIN = ~LLR_MAX;

    typedef enum logic [1:0] {IDLE, SEND, DONE} state_t;

    state_t                    state;
    logic [2*DATA_WIDTH-1:0]   buffer [11:0];
    logic                      mod_qpsk;
    logic [3:0]                idx;
    logic [2:0]                sym_cnt;

    logic [DATA_WIDTH-1:0]     cur_re;
    logic [DATA_WIDTH-1:0]     cur_im;
    logic signed [SW-1:0]      ext_re;
    logic signed [SW-1:0]      ext_im;
    logic signed [SW-1:0]      q_re;
    logic signed [SW-1:0]      q_im;
    logic signed [SW-1:0]      b_sum;
    logic signed [SW-1:0]      b_llr;

    function automatic logic [LLR_WIDTH-1:0] sat(input logic signed [SW-1:0] v);
        if (v > LLR_MAX)
            return LLR_MAX[LLR_WIDTH-1:0];
        else if (v < LLR_MIN)
            return LLR_MIN[LLR_WIDTH-1:0];
        else
            return v[LLR_WIDTH-1:0];
    endfunction

    assign cur_re = buffer[idx][2*DATA_WIDTH-1:DATA_WIDTH];
    assign cur_im = buffer[idx][DATA_WIDTH-1:0];
    assign ext_re = {cur_re[DATA_WIDTH-1], cur_re};
    assign ext_im = {cur_im[DATA_WIDTH-1], cur_im};
    assign q_re   = ext_re >>> QPSK_SHIFT;
    assign q_im   = ext_im >>> QPSK_SHIFT;
    assign b_sum  = ext_re + ext_im;
    assign b_llr  = b_sum >>> BPSK_SHIFT;

    assign o_valid             = (state == SEND);
    assign o_busy              = (state == SEND);
    assign o_done_demap_symbol = (state == DONE);
    assign o_done_demap_slot   = (state == DONE) && (sym_cnt == 3'd5);

    // Soft-bit outputs come from the captured word at the current index; zero when idle.
    always_comb begin
        o_llr0   = '0;
        o_llr1   = '0;
        o_sc_idx = '0;
        if (state == SEND) begin
            o_sc_idx = idx;
            if (mod_qpsk) begin
                o_llr0 = sat(q_re);
                o_llr1 = sat(q_im);
            end else begin
                o_llr0 = sat(b_llr);
            end
        end
    end

    // Main sequencer: capture, serialize under handshake, one-cycle completion.
    always_ff @(posedge i_clk_demap or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state    <= IDLE;
            buffer   <= '{default: '0};
            mod_qpsk <= 1'b0;
            idx      <= '0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (i_done_equ) begin
                        buffer   <= i_equ;
                        mod_qpsk <= i_mod_qpsk;
                        idx      <= '0;
                        state    <= SEND;
                    end else begin
                        state <= IDLE;
                    end
                end
                SEND: begin
                    if (i_ready) begin
                        if (idx == 4'd11)
                            state <= DONE;
                        else
                            idx <= idx + 4'd1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Symbol position within the slot; wraps after the sixth symbol.
    always_ff @(posedge i_clk_demap or negedge i_rst_n) begin
        if (!i_rst_n)
            sym_cnt <= '0;
        else if (state == DONE)
            sym_cnt <= (sym_cnt == 3'd5) ? 3'd0 : sym_cnt + 3'd1;
    end

    // A symbol arriving mid-serialization is lost; remember that until reset.
    always_ff @(posedge i_clk_demap or negedge i_rst_n) begin
        if (!i_rst_n)
            o_overflow <= 1'b0;
        else if (state == SEND && i_done_equ)
            o_overflow <= 1'b1;
    end

endmodule
